// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video memory arbitration slice: PPU mode and OAM
// DMA state encodings, the memory map constants used for address decoding, and
// the FF46 source-page translation helper.
// -----------------------------------------------------------------------------
package video_pkg;

  typedef enum logic [1:0] {
    MODE_HBLANK   = 2'd0,
    MODE_VBLANK   = 2'd1,
    MODE_OAM_SCAN = 2'd2,
    MODE_XFER     = 2'd3
  } ppu_mode_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER,
    DMA_LAST
  } dma_state_t;

  localparam int          OAM_LEN      = 160;
  localparam logic [15:0] VRAM_BASE    = 16'h8000;
  localparam logic [15:0] VRAM_END     = 16'h9FFF;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] OAM_END      = 16'hFE9F;
  localparam logic [15:0] UNUSABLE_END = 16'hFEFF;
  localparam logic [15:0] FF46_ADDR    = 16'hFF46;

  // Source pages E0-FF alias onto C0-DF (echo RAM), so the DMA reads WRAM.
  function automatic logic [7:0] dma_eff_hi(input logic [7:0] src_hi);
    return (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// -----------------------------------------------------------------------------
// oam_dma_engine
// Sequences the FF46 OAM DMA: after a write to FF46 it waits DMA_START_DLY
// cycles, reads OAM_LEN bytes from {eff_hi, idx} and writes each one into OAM
// one cycle later. A new FF46 write restarts the transfer from any state.
//
// Ports
//   clk2          machine-cycle clock
//   reset_video3  synchronous active-high reset
//   ff46_we       CPU write to FF46 this cycle
//   cpu_d_in      CPU write data (new source page on ff46_we)
//   dma_d_in      byte returned on the external bus for dma_a
//   dma_active    engine in START, XFER or LAST
//   dma_rd        read strobe, dma_a is the source address
//   oam_dma_wr    OAM write strobe, oam_dma_a / oam_dma_d index and data
// -----------------------------------------------------------------------------
module oam_dma_engine #(
  parameter int OAM_LEN       = video_pkg::OAM_LEN,
  parameter int DMA_START_DLY = 1
) (
  input  logic        clk2,
  input  logic        reset_video3,
  input  logic        ff46_we,
  input  logic [7:0]  cpu_d_in,
  input  logic [7:0]  dma_d_in,
  output logic        dma_active,
  output logic        dma_rd,
  output logic [15:0] dma_a,
  output logic        oam_dma_wr,
  output logic [7:0]  oam_dma_a,
  output logic [7:0]  oam_dma_d
);
  import video_pkg::*;

  localparam logic [7:0] LAST_IDX   = 8'(OAM_LEN - 1);
  // Only consulted when DMA_START_DLY >= 1; a zero delay skips START entirely.
  localparam logic [7:0] START_LAST = 8'(DMA_START_DLY - 1);

  dma_state_t state;
  logic [7:0] idx;
  logic [7:0] src_hi;
  logic [7:0] start_cnt;
  logic       wr_q;     // an OAM write is staged for this cycle
  logic [7:0] wr_a_q;
  logic [7:0] wr_d_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk2) begin
    if (reset_video3) begin
      state     <= DMA_IDLE;
      idx       <= '0;
      src_hi    <= '0;
      start_cnt <= '0;
      wr_q      <= 1'b0;
      wr_a_q    <= '0;
      wr_d_q    <= '0;
    end else begin
      wr_q <= 1'b0;
      if (ff46_we) begin
        // Restart from any state; the staged write (if any) is dropped.
        src_hi    <= cpu_d_in;
        idx       <= '0;
        start_cnt <= '0;
        state     <= (DMA_START_DLY == 0) ? DMA_XFER : DMA_START;
      end else begin
        unique case (state)
          DMA_IDLE: ;
          DMA_START: begin
            if (start_cnt == START_LAST) state <= DMA_XFER;
            else                         start_cnt <= start_cnt + 8'd1;
          end
          DMA_XFER: begin
            // Byte read this cycle is written to OAM in the next cycle.
            wr_q   <= 1'b1;
            wr_a_q <= idx;
            wr_d_q <= dma_d_in;
            idx    <= idx + 8'd1;
            if (idx == LAST_IDX) state <= DMA_LAST;
          end
          DMA_LAST: state <= DMA_IDLE;
          default:  state <= DMA_IDLE;
        endcase
      end
    end
  end

  assign dma_active = (state != DMA_IDLE);
  assign dma_rd     = (state == DMA_XFER);
  assign dma_a      = dma_rd ? {dma_eff_hi(src_hi), idx} : 16'h0000;

  // A write staged for the cycle of an FF46 write is discarded.
  assign oam_dma_wr = wr_q && !ff46_we;
  assign oam_dma_a  = oam_dma_wr ? wr_a_q : 8'h00;
  assign oam_dma_d  = oam_dma_wr ? wr_d_q : 8'h00;

endmodule

// File: rtl/vram_oam_arbiter.sv
// -----------------------------------------------------------------------------
// vram_oam_arbiter
// Arbitrates VRAM (8000-9FFF) and OAM (FE00-FE9F) between the CPU, the pixel
// pipeline and the OAM DMA engine. Grants are combinational from the current
// PPU mode / LCD enable and the registered DMA state. Blocked CPU reads (and
// any read of FEA0-FEFF) return FF via cpu_rd_ff; blocked writes are dropped
// by the memories when the matching *_cpu_en is low.
//
// Build option: define OAM_DMA_EN to compile in the FF46 DMA engine. Without
// it every dma_* / oam_dma_* output is tied to 0, FF46 writes are ignored and
// OAM arbitration depends on the PPU mode only.
//
// Ports
//   clk2, reset_video3      clock, synchronous active-high reset
//   lcd_on, ppu_mode        video control state
//   cpu_a, cpu_rd2, cpu_wr2 CPU bus address and strobes, cpu_d_in write data
//   dma_d_in                external bus data for dma_a
//   vram_cpu_en, oam_cpu_en CPU access grants
//   cpu_rd_ff               force FF onto the CPU data bus
//   dma_active, dma_rd, dma_a, oam_dma_wr, oam_dma_a, oam_dma_d  DMA side
// -----------------------------------------------------------------------------
module vram_oam_arbiter #(
  parameter int OAM_LEN       = video_pkg::OAM_LEN,
  parameter int DMA_START_DLY = 1
) (
  input  logic        clk2,
  input  logic        reset_video3,
  input  logic        lcd_on,
  input  logic [1:0]  ppu_mode,
  input  logic [15:0] cpu_a,
  input  logic        cpu_rd2,
  input  logic        cpu_wr2,
  input  logic [7:0]  cpu_d_in,
  input  logic [7:0]  dma_d_in,
  output logic        vram_cpu_en,
  output logic        oam_cpu_en,
  output logic        cpu_rd_ff,
  output logic        dma_active,
  output logic        dma_rd,
  output logic [15:0] dma_a,
  output logic        oam_dma_wr,
  output logic [7:0]  oam_dma_a,
  output logic [7:0]  oam_dma_d
);
  import video_pkg::*;

  ppu_mode_t mode;
  logic      vram_busy;
  logic      oam_busy;
  logic      in_vram;
  logic      in_oam;
  logic      in_unusable;

  assign mode = ppu_mode_t'(ppu_mode);

`ifdef OAM_DMA_EN
  logic ff46_we;
  assign ff46_we = cpu_wr2 && (cpu_a == FF46_ADDR);

  oam_dma_engine #(
    .OAM_LEN       (OAM_LEN),
    .DMA_START_DLY (DMA_START_DLY)
  ) u_dma (
    .clk2         (clk2),
    .reset_video3 (reset_video3),
    .ff46_we      (ff46_we),
    .cpu_d_in     (cpu_d_in),
    .dma_d_in     (dma_d_in),
    .dma_active   (dma_active),
    .dma_rd       (dma_rd),
    .dma_a        (dma_a),
    .oam_dma_wr   (oam_dma_wr),
    .oam_dma_a    (oam_dma_a),
    .oam_dma_d    (oam_dma_d)
  );
`else
  assign dma_active = 1'b0;
  assign dma_rd     = 1'b0;
  assign dma_a      = 16'h0000;
  assign oam_dma_wr = 1'b0;
  assign oam_dma_a  = 8'h00;
  assign oam_dma_d  = 8'h00;

  // Inputs that only feed the DMA engine.
  logic unused_dma_inputs;
  assign unused_dma_inputs = ^{clk2, reset_video3, cpu_wr2, cpu_d_in, dma_d_in,
                               8'(OAM_LEN), 8'(DMA_START_DLY)};
`endif

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally) so no latch can be inferred.
  always_comb begin
    in_vram     = (cpu_a >= VRAM_BASE) && (cpu_a <= VRAM_END);
    in_oam      = (cpu_a >= OAM_BASE)  && (cpu_a <= OAM_END);
    in_unusable = (cpu_a >  OAM_END)   && (cpu_a <= UNUSABLE_END);

    vram_busy   = lcd_on && (mode == MODE_XFER);
    oam_busy    = dma_active || (lcd_on && (mode >= MODE_OAM_SCAN));

    vram_cpu_en = !vram_busy;
    oam_cpu_en  = !oam_busy;
    cpu_rd_ff   = cpu_rd2 && ((in_vram && vram_busy) ||
                              (in_oam && oam_busy)   ||
                              in_unusable);
  end

endmodule

// File: tb/tb_vram_oam_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_oam_arbiter
// Stimulus drives one bus cycle per clock and pushes the expected outputs of
// that cycle into a queue; a monitor on the falling edge pops and compares.
// The DMA reference is a single "cycles since FF46 write" counter from which
// the read/write windows and indices follow arithmetically.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vram_oam_arbiter;

  localparam int D = 1;  // DMA_START_DLY

`ifdef OAM_DMA_EN
  localparam bit DMA_EN = 1'b1;
`else
  localparam bit DMA_EN = 1'b0;
`endif

  logic        clk2 = 1'b0;
  logic        reset_video3 = 1'b1;
  logic        lcd_on = 1'b0;
  logic [1:0]  ppu_mode = 2'd0;
  logic [15:0] cpu_a = 16'h0000;
  logic        cpu_rd2 = 1'b0;
  logic        cpu_wr2 = 1'b0;
  logic [7:0]  cpu_d_in = 8'h00;
  logic [7:0]  dma_d_in = 8'h00;
  logic        vram_cpu_en, oam_cpu_en, cpu_rd_ff, dma_active, dma_rd, oam_dma_wr;
  logic [15:0] dma_a;
  logic [7:0]  oam_dma_a, oam_dma_d;

  vram_oam_arbiter #(.OAM_LEN(160), .DMA_START_DLY(D)) dut (
    .clk2         (clk2),
    .reset_video3 (reset_video3),
    .lcd_on       (lcd_on),
    .ppu_mode     (ppu_mode),
    .cpu_a        (cpu_a),
    .cpu_rd2      (cpu_rd2),
    .cpu_wr2      (cpu_wr2),
    .cpu_d_in     (cpu_d_in),
    .dma_d_in     (dma_d_in),
    .vram_cpu_en  (vram_cpu_en),
    .oam_cpu_en   (oam_cpu_en),
    .cpu_rd_ff    (cpu_rd_ff),
    .dma_active   (dma_active),
    .dma_rd       (dma_rd),
    .dma_a        (dma_a),
    .oam_dma_wr   (oam_dma_wr),
    .oam_dma_a    (oam_dma_a),
    .oam_dma_d    (oam_dma_d)
  );

  always #5 clk2 = ~clk2;

  // {vram_cpu_en, oam_cpu_en, cpu_rd_ff, dma_active, dma_rd, dma_a,
  //  oam_dma_wr, oam_dma_a, oam_dma_d}
  typedef logic [37:0] vec_t;

  vec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state: t = cycles since the last FF46 write (0 = no DMA).
  int         t = 0;
  logic [7:0] src = 8'h00;
  logic [7:0] prev_d = 8'h00;

  function automatic bit ff46_now();
    return DMA_EN && cpu_wr2 && (cpu_a == 16'hFF46);
  endfunction

  function automatic vec_t expect_now();
    bit         vb, ob, rdff, act, rd, wr;
    int         off;
    logic [7:0] hi, oa, od;
    logic [15:0] a;
    act = (t > 0);
    off = t - D;
    rd  = act && (off >= 1) && (off <= 160);
    wr  = act && (off >= 2) && (off <= 161) && !ff46_now();
    hi  = (src >= 8'hE0) ? src - 8'h20 : src;
    a   = rd ? {hi, 8'(off - 1)} : 16'h0000;
    oa  = wr ? 8'(off - 2) : 8'h00;
    od  = wr ? prev_d : 8'h00;
    vb  = lcd_on && (ppu_mode == 2'd3);
    ob  = act || (lcd_on && (ppu_mode >= 2'd2));
    rdff = cpu_rd2 && (((cpu_a >= 16'h8000) && (cpu_a <= 16'h9FFF) && vb) ||
                       ((cpu_a >= 16'hFE00) && (cpu_a <= 16'hFE9F) && ob) ||
                       ((cpu_a >= 16'hFEA0) && (cpu_a <= 16'hFEFF)));
    return {!vb, !ob, rdff, act, rd, a, wr, oa, od};
  endfunction

  task automatic advance_model();
    if (reset_video3) begin
      t   = 0;
      src = 8'h00;
    end else if (ff46_now()) begin
      t   = 1;
      src = cpu_d_in;
    end else if (t > 0) begin
      t = (t >= D + 161) ? 0 : t + 1;
    end
    prev_d = dma_d_in;
  endtask

  task automatic step(input bit rst, input bit lcd, input logic [1:0] mode,
                      input logic [15:0] a, input bit rd, input bit wr,
                      input logic [7:0] d, input logic [7:0] dd,
                      input bit chk = 1'b1);
    @(posedge clk2);
    #1;
    reset_video3 = rst;
    lcd_on       = lcd;
    ppu_mode     = mode;
    cpu_a        = a;
    cpu_rd2      = rd;
    cpu_wr2      = wr;
    cpu_d_in     = d;
    dma_d_in     = dd;
    if (chk) exp_q.push_back(expect_now());
    advance_model();
  endtask

  task automatic rand_step(input int ff46_odds, input int rst_odds);
    logic [15:0] a;
    bit          rd, wr, rst;
    int          r;
    r = $urandom_range(9, 0);
    if (r < 4)      a = 16'h8000 + 16'($urandom_range(16'h1FFF, 0));
    else if (r < 8) a = 16'hFE00 + 16'($urandom_range(16'h00FF, 0));
    else            a = 16'($urandom);
    rd = 1'($urandom);
    wr = !rd && 1'($urandom);
    if (a == 16'hFF46) wr = 1'b0;
    if (ff46_odds > 0 && $urandom_range(ff46_odds - 1, 0) == 0) begin
      a  = 16'hFF46;
      rd = 1'b0;
      wr = 1'b1;
    end
    rst = (rst_odds > 0) && ($urandom_range(rst_odds - 1, 0) == 0);
    step(rst, ($urandom_range(3, 0) != 0), 2'($urandom), a, rd, wr,
         8'($urandom), 8'($urandom));
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  vec_t got, want;
  always @(negedge clk2) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {vram_cpu_en, oam_cpu_en, cpu_rd_ff, dma_active, dma_rd, dma_a,
              oam_dma_wr, oam_dma_a, oam_dma_d};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL outputs vec %0d @%0t: got %h expected %h",
                 vectors, $time, got, want);
      end
    end
  end

  initial begin
    // Reset; outputs are unknown until the first reset edge, so not checked.
    step(1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 8'h00, 1'b0);
    step(1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 8'h00);
    step(0, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 8'h00);

    // VRAM blocking and same-cycle release.
    step(0, 1, 2'd3, 16'h8100, 1, 0, 8'h00, 8'h00);
    step(0, 1, 2'd0, 16'h8100, 1, 0, 8'h00, 8'h00);
    // OAM blocking by mode, granted with LCD off; FEA0-FEFF always FF.
    step(0, 1, 2'd2, 16'hFE10, 0, 1, 8'h5A, 8'h00);
    step(0, 0, 2'd2, 16'hFE10, 0, 1, 8'h5A, 8'h00);
    step(0, 0, 2'd0, 16'hFEB0, 1, 0, 8'h00, 8'h00);

    // Full DMA from C1.
    step(0, 1, 2'd0, 16'hFF46, 0, 1, 8'hC1, 8'h00);
    repeat (165) rand_step(0, 0);

    // E3 aliases to C3; restart at idx 50.
    step(0, 1, 2'd1, 16'hFF46, 0, 1, 8'hE3, 8'h00);
    repeat (D + 50) rand_step(0, 0);
    step(0, 1, 2'd1, 16'hFF46, 0, 1, 8'h42, 8'h11);
    repeat (170) rand_step(0, 0);

    // FF46 write during LAST suppresses the index-159 write.
    step(0, 0, 2'd0, 16'hFF46, 0, 1, 8'h10, 8'h00);
    repeat (D + 160) rand_step(0, 0);
    step(0, 0, 2'd0, 16'hFF46, 0, 1, 8'hFF, 8'h22);
    repeat (170) rand_step(0, 0);

    // Reset in the middle of XFER.
    step(0, 1, 2'd2, 16'hFF46, 0, 1, 8'h20, 8'h00);
    repeat (30) rand_step(0, 0);
    step(1, 1, 2'd2, 16'h0000, 0, 0, 8'h00, 8'h33);
    repeat (5) rand_step(0, 0);

    // Randomized mix with occasional restarts and resets.
    repeat (4000) rand_step(400, 700);
    repeat (4) step(0, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 8'h00);

    repeat (2) @(negedge clk2);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
